// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver: sync/filter, 11-bit frame FSM with timeout, and
// E0/F0/E1 prefix parser producing the {toggle, pressed, extended, code} word.
module ps2_key_encoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 30000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic [7:0]  rx_byte,
  output logic        rx_strobe,
  output logic        frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_s, dat_s;
  logic          clk_f_q;
  logic [FW-1:0] filt_cnt_q;
  logic          fall;

  state_t        state_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    rx_byte_q;
  logic          rx_strobe_q, frame_err_q;

  logic [10:0]   key_q;
  logic          ext_q, brk_q;
  logic [2:0]    skip_q;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  // The filtered clock falls on the FILTER_LEN-th consecutive low sample;
  // that same cycle is the bit-sample point.
  assign fall  = clk_f_q && !clk_s && (filt_cnt_q == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_f_q    <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      if (clk_s == clk_f_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_f_q    <= clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      rx_byte_q   <= '0;
      rx_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall && !dat_s) begin
            state_q   <= RECV;
            bit_cnt_q <= 4'd1;
            par_q     <= 1'b0;
            tmo_q     <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            tmo_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q <= 4'd8) begin
              shift_q <= {dat_s, shift_q[7:1]};
              par_q   <= par_q ^ dat_s;
            end else if (bit_cnt_q == 4'd9) begin
              par_q   <= par_q ^ dat_s;
            end else begin
              state_q   <= IDLE;
              bit_cnt_q <= '0;
              // par_q is set when data plus parity carries an odd number of ones
              if (par_q && dat_s) begin
                rx_byte_q   <= shift_q;
                rx_strobe_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            frame_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_q  <= '0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= '0;
    end else if (frame_err_q) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= '0;
    end else if (rx_strobe_q) begin
      if (skip_q != 3'd0) begin
        skip_q <= skip_q - 3'd1;
      end else if (rx_byte_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else if (rx_byte_q == 8'hE1) begin
        // Pause: swallow the remaining seven bytes of the sequence
        skip_q <= 3'd7;
        ext_q  <= 1'b0;
        brk_q  <= 1'b0;
      end else if (rx_byte_q inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else begin
        key_q <= {~key_q[10], ~brk_q, ext_q, rx_byte_q};
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  assign ps2_key   = key_q;
  assign rx_byte   = rx_byte_q;
  assign rx_strobe = rx_strobe_q;
  assign frame_err = frame_err_q;

endmodule
